// File: rtl/midi_rx.sv
// midi_rx: 31250-baud MIDI UART receiver with a 4-byte FIFO and CPU read port.
// Ports: clock/reset (sync, low), ce oversample enable, rx serial line,
//   iorq/rd (low) + cs + a CPU read (a=0 data, a=1 status), q read data,
//   irq high while the FIFO holds data.
`timescale 1ns/1ps
module midi_rx #(
  parameter int DIV = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       rx,
  input  logic       iorq,
  input  logic       rd,
  input  logic       cs,
  input  logic       a,
  output logic [7:0] q,
  output logic       irq
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAITHI
  } state_t;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  state_t state, state_n;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    sub;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          push, ferr_set, shift_en;

  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic       ovr, ferr;
  logic       empty, full;
  logic       acc, d_acc, s_acc;
  logic       d_acc_q, s_acc_q;
  logic       pop, s_end;
  logic       pop_ok, push_ok, ovr_set;
  logic [7:0] status;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = ce && (cnt == CMAX);

  always_ff @(posedge clock) begin
    if (!reset || state == IDLE) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    ferr_set = 1'b0;
    shift_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (tick && sub == 4'd7) begin
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && sub == 4'hf) begin
          shift_en = 1'b1;
          if (bitn == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick && sub == 4'hf) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAITHI;
          end
        end
      end
      WAITHI: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // sub restarts at the mid start bit so later
  // samples land every 16 ticks from there
  always_ff @(posedge clock) begin
    if (!reset) begin
      sub  <= '0;
      bitn <= '0;
      sh   <= '0;
    end else if (state == IDLE) begin
      sub  <= '0;
      bitn <= '0;
    end else if (tick) begin
      if (state == START && sub == 4'd7) begin
        sub <= '0;
      end else begin
        sub <= sub + 1'b1;
      end
      if (shift_en) begin
        sh   <= {rx_s, sh[7:1]};
        bitn <= bitn + 1'b1;
      end
    end
  end

  assign acc   = !iorq && !rd && cs;
  assign d_acc = acc && !a;
  assign s_acc = acc && a;

  // one pop / one flag clear per access,
  // taken on the clock the access goes away
  assign pop   = d_acc_q && !d_acc;
  assign s_end = s_acc_q && !s_acc;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign ovr_set = push && full && !pop_ok;

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else if (push_ok) begin
      mem[wp] <= sh;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      ovr     <= 1'b0;
      ferr    <= 1'b0;
      d_acc_q <= 1'b0;
      s_acc_q <= 1'b0;
    end else begin
      d_acc_q <= d_acc;
      s_acc_q <= s_acc;
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + 3'(push_ok) - 3'(pop_ok);
      ovr   <= ovr_set  | (ovr  & ~s_end);
      ferr  <= ferr_set | (ferr & ~s_end);
    end
  end

  assign status = {3'b000, state != IDLE,
                   ferr, ovr, full, !empty};
  assign q      = a ? status : mem[rp];
  assign irq    = !empty;

endmodule

// File: doc/midi_rx.md
MIDI_RX -- requirements
Module: midi_rx

Interface
REQ-001 Parameter: DIV, default 7, number of ce pulses per 1/16 bit-time (3.5 MHz ce / 7 = 16 x 31250 baud).
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 ce  input  1  clock enable; the oversample divider advances only when ce=1.
REQ-005 rx  input  1  asynchronous MIDI serial line, 8N1, idle high.
REQ-006 iorq  input  1  active-low CPU I/O request.
REQ-007 rd  input  1  active-low CPU read strobe.
REQ-008 cs  input  1  active-high port decode from the parent block.
REQ-009 a  input  1  register select: 0=data, 1=status.
REQ-010 q  output  8  read data: the FIFO head when a=0, the status byte when a=1.
REQ-011 irq  output  1  high while the FIFO is non-empty.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before use; the synchronizer resets to 1.
REQ-013 Tick: a counter SHALL count ce pulses 0..DIV-1 and emit a one-clock tick on wrap; the counter is cleared when the state machine is in IDLE.
REQ-014 States SHALL be IDLE, START, DATA, STOP and WAITHI.
REQ-015 IDLE->START on a synchronized rx of 0; the tick counter and the 4-bit sub-bit counter are zeroed.
REQ-016 START: after 8 ticks (mid start bit), go to DATA if rx=0; otherwise treat it as a glitch and return to IDLE with nothing pushed.
REQ-017 DATA: sample rx every 16 ticks and shift bits in LSB first; after the 8th sample, go to STOP.
REQ-018 STOP: sample rx 16 ticks after the last data sample.
- rx=1: push the byte and go to IDLE.
- rx=0: set the ferr flag, discard the byte and go to WAITHI.
REQ-019 WAITHI: stay until the synchronized rx is 1, then go to IDLE.
REQ-020 The FIFO SHALL be 4 entries x 8 bits, using 2-bit read/write pointers, a 3-bit count and wrap-around indexing.
REQ-021 A data read access is iorq=0, rd=0, cs=1, a=0. The FIFO pops on the first clock on which the access is no longer present after having been present, so each access pops exactly one byte.
REQ-022 A pop while the FIFO is empty SHALL be ignored; q then shows the stale head entry.
REQ-023 A push while the FIFO is full and no pop occurs SHALL drop the byte and set the sticky ovr flag.
REQ-024 A push and a pop in the same clock SHALL both take effect, leaving the count unchanged; there is no overrun even when the FIFO is full.
REQ-025 Status byte layout:
- bit0: not empty
- bit1: full
- bit2: ovr
- bit3: ferr
- bit4: receiver busy (state other than IDLE)
- bits7:5: 0
REQ-026 ovr and ferr SHALL clear on the access-end clock of a status read (same edge detection as REQ-021, with a=1). A set event occurring on that same clock wins over the clear.
REQ-027 Latency: a pushed byte SHALL be visible in status bit0 and on irq on the clock after the stop-bit sample tick.
REQ-028 q SHALL be combinational from a, the FIFO head and the status flags; it is not gated by iorq or rd.

Reset
REQ-029 On reset=0 at a clock edge, the following SHALL be cleared:
- state to IDLE
- tick and bit counters to 0
- FIFO pointers and count to 0
- ovr and ferr to 0
- shift register to 0x00
- synchronizer to 1
REQ-030 After reset, the outputs SHALL be irq=0, and q=0x00 with a=1.
REQ-031 A reset asserted mid-frame SHALL abandon the frame. Reception resumes only at the next 1->0 transition after reset releases; a line already low at release waits in IDLE and starts immediately, with no requirement to reject that partial frame beyond the START glitch check.

Verification
REQ-032 Send 0x90 at 31250 baud (ce=3.5 MHz, DIV=7) -> irq rises 1 clock after the mid-stop sample; status reads 0x01; a data read returns 0x90; status then reads 0x00 and irq=0.
REQ-033 Drive rx low for 4 ticks then high -> the state returns to IDLE, no push occurs and status stays 0x00.
REQ-034 Send 0x3C with stop bit=0 -> status reads 0x08 (ferr, FIFO empty); the next status read returns 0x00; the receiver waits for rx=1 before accepting the next frame.
REQ-035 Send 0x01..0x05 with no reads -> status reads 0x06|0x01=0x07; data reads return 0x01,0x02,0x03,0x04 in order, after which status reads 0x00.
REQ-036 With the FIFO full, complete a data-read access ending on the exact push clock of a 5th byte -> no ovr; the FIFO still holds 4 bytes and the newest byte is at the tail.
REQ-037 Assert reset midway through byte 0x55 -> on release: irq=0, status 0x00; a following clean 0xAA frame is received as 0xAA.
